// File: rtl/value_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | value_capture: samples a counter value on capture into a FWFT FIFO,         |
// | flags value_in >= threshold. Optional: VALUE_CAPTURE_DELTA_EN stores deltas.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module value_capture #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [WIDTH-1:0]         value_in,
  input  logic                     capture,
  input  logic [WIDTH-1:0]         threshold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    next_rd;
  logic [AW:0]      count_q;
  logic [AW:0]      next_count;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] store_val;
  logic             push;
  logic             pop;
  logic             drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign out_data  = head_q;

  assign pop     = out_valid && out_ready;
  assign push    = capture && (!full || pop);
  assign drop    = capture && !push;
  assign next_rd = rd_ptr + AW'(pop);

  always_comb begin
    next_count = count_q;
    if (push && !pop) begin
      next_count = count_q + 1'b1;
    end else if (pop && !push) begin
      next_count = count_q - 1'b1;
    end
  end

`ifdef VALUE_CAPTURE_DELTA_EN
  logic [WIDTH-1:0] last_captured;

  assign store_val = value_in - last_captured;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      last_captured <= '0;
    end else if (push) begin
      last_captured <= value_in;
    end
  end
`else
  assign store_val = value_in;
`endif

  // Storage array carries no reset; only slots behind valid pointers are read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= store_val;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      head_q   <= '0;
      overflow <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr  <= next_rd;
      count_q <= next_count;
      // Registered head: the slot being written this cycle bypasses the array;
      // when the FIFO drains the last head value is held.
      if (next_count != '0) begin
        head_q <= (push && (wr_ptr == next_rd)) ? store_val : mem[next_rd];
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      alarm <= (value_in >= threshold);
    end
  end

endmodule
`default_nettype wire
